// File: rtl/trng_conditioner.sv
// Conditions raw TRNG bytes: start-up discard, repetition-count health test,
// von Neumann debiasing, byte repacking and a small FWFT output FIFO.
module trng_conditioner #(
    parameter int STARTUP_BYTES = 16,
    parameter int RCT_LIMIT     = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [7:0]                    raw_byte_i,
    input  logic                          raw_valid_i,
    output logic [7:0]                    out_data_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          alarm_o,
    output logic                          drop_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        RUN     = 2'd1,
        ALARM   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      prevByte_q, prevByte_d;
    logic [7:0]      rctCnt_q, rctCnt_d;
    logic [7:0]      startCnt_q, startCnt_d;
    logic [11:0]     acc_q, acc_d;
    logic [3:0]      accCnt_q, accCnt_d;
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [PW:0]     count_q, count_d;
    logic            drop_q, drop_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic [7:0]      rctNext;
    logic            rctFire;
    logic [3:0]      emitBits;
    logic [2:0]      emitN;
    logic [11:0]     accShift;
    logic [11:0]     accAligned;
    logic [3:0]      accSum;
    logic            byteDone;
    logic [7:0]      byteVal;
    logic            full;
    logic            pop;
    logic            pushEn;
    logic            flush;

    // Repetition-count test: the first byte after reset always starts a run of one.
    assign rctNext = (rctCnt_q == 8'd0 || raw_byte_i != prevByte_q) ? 8'd1 : rctCnt_q + 8'd1;
    assign rctFire = raw_valid_i && (state_q != ALARM) && (rctNext == 8'(RCT_LIMIT));

    always_comb begin
        emitBits = 4'd0;
        emitN    = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (raw_byte_i[2*i+1] != raw_byte_i[2*i]) begin
                emitBits = {emitBits[2:0], raw_byte_i[2*i+1]};
                emitN    = emitN + 3'd1;
            end
        end
    end

    // Oldest bits sit highest in the accumulator; accCnt_q never exceeds 7 between bytes.
    assign accShift   = (acc_q << emitN) | {8'h00, emitBits};
    assign accSum     = accCnt_q + {1'b0, emitN};
    assign byteDone   = (accSum >= 4'd8);
    assign accAligned = accShift >> (accSum - 4'd8);
    assign byteVal    = accAligned[7:0];

    assign full        = (count_q == (PW+1)'(FIFO_DEPTH));
    assign out_valid_o = (count_q != '0) && (state_q != ALARM);
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        state_d    = state_q;
        prevByte_d = prevByte_q;
        rctCnt_d   = rctCnt_q;
        startCnt_d = startCnt_q;
        acc_d      = acc_q;
        accCnt_d   = accCnt_q;
        pushEn     = 1'b0;
        drop_d     = 1'b0;
        flush      = 1'b0;
        if (raw_valid_i && state_q != ALARM) begin
            prevByte_d = raw_byte_i;
            rctCnt_d   = rctNext;
        end
        case (state_q)
            STARTUP: begin
                if (raw_valid_i) begin
                    if (rctFire) begin
                        state_d = ALARM;
                        flush   = 1'b1;
                    end else begin
                        startCnt_d = startCnt_q + 8'd1;
                        if (startCnt_q + 8'd1 == 8'(STARTUP_BYTES)) begin
                            state_d = RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (raw_valid_i) begin
                    if (rctFire) begin
                        state_d = ALARM;
                        flush   = 1'b1;
                    end else begin
                        acc_d    = accShift;
                        accCnt_d = byteDone ? accSum - 4'd8 : accSum;
                        if (byteDone) begin
                            if (!full || pop) begin
                                pushEn = 1'b1;
                            end else begin
                                drop_d = 1'b1;
                            end
                        end
                    end
                end
            end
            default: begin
            end
        endcase
        if (flush) begin
            acc_d    = 12'd0;
            accCnt_d = 4'd0;
        end
    end

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            if (pushEn) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            case ({pushEn, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= STARTUP;
            prevByte_q <= 8'd0;
            rctCnt_q   <= 8'd0;
            startCnt_q <= 8'd0;
            acc_q      <= 12'd0;
            accCnt_q   <= 4'd0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prevByte_q <= prevByte_d;
            rctCnt_q   <= rctCnt_d;
            startCnt_q <= startCnt_d;
            acc_q      <= acc_d;
            accCnt_q   <= accCnt_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
        end
    end

    // Storage needs no reset: the pointers and count decide what is visible.
    always_ff @(posedge clk_i) begin
        if (pushEn && !reset_i) begin
            mem_q[wrPtr_q] <= byteVal;
        end
    end

    assign out_data_o   = out_valid_o ? mem_q[rdPtr_q] : 8'h00;
    assign alarm_o      = (state_q == ALARM);
    assign drop_o       = drop_q;
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_trng_conditioner.sv
// Self-checking bench for trng_conditioner: directed scenarios plus random
// traffic, compared every cycle against a bit-queue model of the conditioner.
module tb_trng_conditioner;

    localparam int STARTUP_BYTES = 4;
    localparam int RCT_LIMIT     = 8;
    localparam int FIFO_DEPTH    = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rawByte = 8'h00;
    logic       rawValid = 1'b0;
    logic       outReady = 1'b0;
    logic [7:0] outData;
    logic       outValid;
    logic       alarm;
    logic       drop;
    logic [$clog2(FIFO_DEPTH):0] fifoCount;

    int totalChecks = 0;
    int badChecks   = 0;
    logic checkEn   = 1'b0;

    // Reference model state: a stream of debiased bits and a queue of finished bytes.
    bit         bitsQ[$];
    logic [7:0] fifoQ[$];
    bit         mAlarm;
    bit         mDrop;
    int         mStart;
    int         mRct;
    logic [7:0] mPrev;
    logic [7:0] mByte;

    trng_conditioner #(
        .STARTUP_BYTES(STARTUP_BYTES),
        .RCT_LIMIT    (RCT_LIMIT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .raw_byte_i  (rawByte),
        .raw_valid_i (rawValid),
        .out_data_o  (outData),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .alarm_o     (alarm),
        .drop_o      (drop),
        .fifo_count_o(fifoCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input int act, input int exp);
        totalChecks++;
        if (act != exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic v, input logic r);
        rawByte  = b;
        rawValid = v;
        outReady = r;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            bitsQ.delete();
            fifoQ.delete();
            mAlarm = 1'b0;
            mDrop  = 1'b0;
            mStart = 0;
            mRct   = 0;
            mPrev  = 8'h00;
        end else begin
            mDrop = 1'b0;
            if (!mAlarm && fifoQ.size() != 0 && outReady) begin
                void'(fifoQ.pop_front());
            end
            if (rawValid && !mAlarm) begin
                if (mRct == 0 || rawByte != mPrev) mRct = 1;
                else mRct = mRct + 1;
                mPrev = rawByte;
                if (mRct == RCT_LIMIT) begin
                    mAlarm = 1'b1;
                    fifoQ.delete();
                    bitsQ.delete();
                end else if (mStart < STARTUP_BYTES) begin
                    mStart = mStart + 1;
                end else begin
                    for (int p = 3; p >= 0; p--) begin
                        if (rawByte[2*p+1] != rawByte[2*p]) bitsQ.push_back(rawByte[2*p+1]);
                    end
                    if (bitsQ.size() >= 8) begin
                        mByte = 8'h00;
                        for (int k = 0; k < 8; k++) mByte = {mByte[6:0], bitsQ.pop_front()};
                        if (fifoQ.size() < FIFO_DEPTH) fifoQ.push_back(mByte);
                        else mDrop = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model out_valid", int'(outValid), int'(fifoQ.size() != 0));
            checkOutput("model fifo_count", int'(fifoCount), fifoQ.size());
            checkOutput("model alarm", int'(alarm), int'(mAlarm));
            checkOutput("model drop", int'(drop), int'(mDrop));
            if (fifoQ.size() != 0) checkOutput("model out_data", int'(outData), int'(fifoQ[0]));
        end
    end

    logic [7:0] fillSeq [10] = '{8'hAA, 8'h9A, 8'hAA, 8'hA6, 8'hAA, 8'h9A, 8'hAA, 8'hA6, 8'hAA, 8'h9A};
    logic [7:0] readExp [4]  = '{8'hFD, 8'hFE, 8'hFD, 8'hFE};
    int         dropSeen;
    logic [7:0] lastRb;
    logic [7:0] rb;

    initial begin
        reset = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        checkEn = 1'b1;
        checkOutput("reset out_valid", int'(outValid), 0);
        checkOutput("reset out_data", int'(outData), 0);
        checkOutput("reset alarm", int'(alarm), 0);
        checkOutput("reset drop", int'(drop), 0);
        checkOutput("reset fifo_count", int'(fifoCount), 0);
        for (int i = 0; i < 10; i++) applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("idle out_valid", int'(outValid), 0);

        $display("[TB] start-up window then first byte");
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        applyStimulus(8'h33, 1'b1, 1'b0);
        applyStimulus(8'h44, 1'b1, 1'b0);
        checkOutput("startup no output", int'(fifoCount), 0);
        applyStimulus(8'hAA, 1'b1, 1'b0);
        checkOutput("half byte out_valid", int'(outValid), 0);
        applyStimulus(8'hAA, 1'b1, 1'b0);
        checkOutput("first byte out_valid", int'(outValid), 1);
        checkOutput("first byte out_data", int'(outData), 8'hFF);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("first byte popped", int'(outValid), 0);

        $display("[TB] 0x96 pair and alternating 0x00/0xFF");
        applyStimulus(8'h96, 1'b1, 1'b1);
        applyStimulus(8'h96, 1'b1, 1'b1);
        checkOutput("0x96 pair out_data", int'(outData), 8'h99);
        for (int i = 0; i < 20; i++) applyStimulus((i % 2 == 0) ? 8'h00 : 8'hFF, 1'b1, 1'b1);
        checkOutput("alternating out_valid", int'(outValid), 0);
        checkOutput("alternating alarm", int'(alarm), 0);

        $display("[TB] leftover bit carried into the next byte");
        applyStimulus(8'h40, 1'b1, 1'b0);
        applyStimulus(8'h96, 1'b1, 1'b0);
        applyStimulus(8'h96, 1'b1, 1'b0);
        checkOutput("nine bits out_data", int'(outData), 8'h4C);
        checkOutput("nine bits count", int'(fifoCount), 1);
        applyStimulus(8'h96, 1'b1, 1'b0);
        applyStimulus(8'hAA, 1'b1, 1'b0);
        checkOutput("leftover count", int'(fifoCount), 2);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("leftover next byte", int'(outData), 8'hCF);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("drained", int'(fifoCount), 0);

        $display("[TB] overflow with out_ready low");
        dropSeen = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(fillSeq[i], 1'b1, 1'b0);
            if (drop) dropSeen++;
        end
        checkOutput("full count", int'(fifoCount), FIFO_DEPTH);
        checkOutput("drop pulses", dropSeen, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("readout order", int'(outData), int'(readExp[i]));
            applyStimulus(8'h00, 1'b0, 1'b1);
        end
        checkOutput("readout empty", int'(outValid), 0);

        $display("[TB] random traffic");
        lastRb = 8'h00;
        for (int i = 0; i < 400; i++) begin
            rb = ($urandom_range(0, 3) == 0) ? lastRb : 8'($urandom);
            lastRb = rb;
            applyStimulus(rb, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
        end
        reset = 1'b1;
        applyStimulus(8'($urandom), 1'b1, 1'b0);
        reset = 1'b0;
        checkOutput("mid reset count", int'(fifoCount), 0);
        checkOutput("mid reset alarm", int'(alarm), 0);

        $display("[TB] repetition-count alarm");
        for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b1, 1'b0);
        applyStimulus(8'hAA, 1'b1, 1'b0);
        applyStimulus(8'h9A, 1'b1, 1'b0);
        applyStimulus(8'hAA, 1'b1, 1'b0);
        applyStimulus(8'h9A, 1'b1, 1'b0);
        checkOutput("pre-alarm count", int'(fifoCount), 2);
        checkOutput("pre-alarm out_data", int'(outData), 8'hFB);
        for (int i = 0; i < 7; i++) applyStimulus(8'h3C, 1'b1, 1'b0);
        checkOutput("seventh repeat alarm", int'(alarm), 0);
        applyStimulus(8'h3C, 1'b1, 1'b0);
        checkOutput("eighth repeat alarm", int'(alarm), 1);
        checkOutput("alarm flush count", int'(fifoCount), 0);
        checkOutput("alarm out_valid", int'(outValid), 0);
        for (int i = 0; i < 20; i++) applyStimulus(8'($urandom), 1'b1, 1'b1);
        checkOutput("alarm sticky", int'(alarm), 1);
        checkOutput("alarm silent", int'(outValid), 0);

        reset = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("alarm cleared", int'(alarm), 0);

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/trng_conditioner.md
# trng_conditioner

Post-processing stage directly downstream of the ring-oscillator TRNG byte generator. It accepts raw 8-bit samples, discards a start-up window, and runs a repetition-count health test on the raw stream. Raw samples are debiased with a von Neumann extractor, repacked into full bytes and buffered in a small first-word-fall-through FIFO. Consumers read the FIFO through a valid/ready interface.

## Interface
- STARTUP_BYTES, 16: number of raw bytes discarded after reset before extraction begins (1..255).
- RCT_LIMIT, 32: consecutive identical raw bytes that trigger the alarm (2..255).
- FIFO_DEPTH, 4: output FIFO entries; power of two, 2..16.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- raw_byte  input  8  raw sample from the TRNG.
- raw_valid  input  1  raw_byte is sampled this cycle. There is no back-pressure; every valid byte is consumed.
- out_data  output  8  conditioned byte at the FIFO head.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- alarm  output  1  sticky health-test failure; cleared only by reset.
- drop  output  1  one-cycle pulse: a completed byte was discarded because the FIFO was full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- FSM has three states: STARTUP, RUN and ALARM.
  - reset forces STARTUP.
  - STARTUP→RUN when the STARTUP_BYTES-th valid raw byte is accepted.
  - STARTUP/RUN→ALARM when the RCT fires.
  - ALARM is terminal until reset.
- Repetition-count test (RCT), active in STARTUP and RUN:
  - Registers prev_byte and rct_cnt (8 bits).
  - The first valid byte after reset sets rct_cnt=1.
  - Each following valid byte: rct_cnt increments if raw_byte==prev_byte, otherwise resets to 1. prev_byte is then updated.
  - The RCT fires when rct_cnt reaches RCT_LIMIT.
- In STARTUP, bytes feed only the RCT and the start-up counter; nothing is extracted.
- Extraction (RUN only): each raw byte is split into bit pairs in order (b7,b6), (b5,b4), (b3,b2), (b1,b0).
  - An unequal pair emits its high bit (10→1, 01→0).
  - An equal pair emits nothing.
  - One raw byte yields 0..4 bits.
- Packing:
  - Emitted bits shift into a 12-bit accumulator at the LSB, earliest bit first; acc_cnt counts valid bits (0..11).
  - When acc_cnt ≥ 8 after the shift, the oldest 8 bits form one output byte (first-emitted bit = MSB), are pushed to the FIFO, and acc_cnt −= 8. Leftover bits are kept.
- FIFO:
  - A pop occurs on out_valid && out_ready.
  - A push while full is permitted only if a pop happens in the same cycle. Otherwise the byte is discarded and drop pulses.
  - Ordering is strict FIFO.
- On entering ALARM:
  - The FIFO is flushed and the accumulator cleared, both on the same edge that sets alarm.
  - Further raw bytes are ignored.
  - out_valid stays 0 and out_ready is ignored.
  - A byte completing on the alarm-raising raw byte is discarded, and drop does not pulse.
- raw_valid=0: no state changes except FIFO pops.

## Timing
- Reset values: out_data=0, out_valid=0, alarm=0, drop=0, fifo_count=0; acc_cnt, rct_cnt and the start-up counter are 0.
- A raw byte accepted at edge N that completes an output byte gives out_valid=1 and the byte on out_data in the cycle after edge N (1-cycle latency).
- alarm rises in the cycle after the edge that accepts the RCT_LIMIT-th identical byte. From that cycle out_valid=0 and fifo_count=0.
- drop is high for exactly the one cycle following the discarding edge.
- out_data is valid and stable whenever out_valid=1 and no pop has occurred.
- A pop at edge N presents the next entry in cycle N+1.
- Simultaneous push and pop on an empty FIFO is not possible; the pushed byte appears next cycle.
- Reset asserted mid-stream: on the next edge all state returns to the reset values, including partial accumulator bits and the FIFO contents.

## Test plan
- Reset, then raw_valid=0 for 10 cycles → out_valid=0, alarm=0, drop=0, fifo_count=0 throughout.
- STARTUP_BYTES=4: send 4 distinct bytes, then 0xAA, 0xAA → nothing emitted for the first 4; out_data=0xFF with out_valid=1 the cycle after the second 0xAA.
- Send 0x96, 0x96 with out_ready=1 → one byte 0x99; send 0x00, 0xFF alternately ×20 → no output and no alarm.
- Send 0x40 then 0x96, 0x96 → 9 bits accumulated; out_data=0x4C is emitted and 1 leftover bit (1) remains. Checker compares the next byte.
- RCT_LIMIT=8, FIFO holding 2 bytes: send 0x3C ×8 → alarm=1 the cycle after the 8th; fifo_count=0 and out_valid=0; further varied input produces nothing until reset.
- FIFO_DEPTH=4, out_ready=0: complete 5 bytes → fifo_count=4, drop pulses once on the 5th. Then out_ready=1 → 4 bytes read in push order.
